data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
- Load/store data memory for the single-cycle RISC-V core; sits directly upstream of the writeback result multiplexer and drives its RD input.
- Takes the ALU-computed address and the store data from the register file, performs byte, halfword and word stores synchronously, and returns sign- or zero-extended load data combinationally in the same cycle.
- Keeps a sticky misalignment/illegal-access status register for debug.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the memory array; must be a power of 2.
- IDX_W, 6, word index width, equal to log2(DEPTH_WORDS).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears the array and all registers.
- MemWrite, input, 1, store enable for this cycle.
- MemRead, input, 1, load qualifier; when 0, RD = 0.
- ALUResult, input, 32, byte address.
- WriteData, input, 32, store data; low bits are used for SB and SH.
- funct3, input, 3, access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RD, output, 32, extended load data (combinational).
- AccessFault, output, 1, combinational pulse for a misaligned or illegal access this cycle.
- FaultSticky, output, 1, registered flag; set on any fault, cleared only by reset.
- FaultAddr, output, 32, registered address of the first fault since reset.
- StoreCount, output, 16, registered count of completed stores; wraps.

Behaviour:
- Reset (asynchronous, any time): all array words = 0, FaultSticky = 0, FaultAddr = 0, StoreCount = 0. RD follows the cleared array, so RD = 0. Reset dominates any MemWrite at the same edge.
- Indexing: word index = ALUResult[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte lane = ALUResult[1:0]. Halfword lane = ALUResult[1].
- Loads are combinational, zero-cycle latency:
  - LB/LBU: selected byte, sign- or zero-extended to 32 bits.
  - LH/LHU: selected halfword, sign- or zero-extended.
  - LW: full word.
- Stores are written at the rising clk edge when MemWrite = 1 and the access is legal:
  - SB writes only the selected byte lane from WriteData[7:0].
  - SH writes the selected halfword from WriteData[15:0].
  - SW writes the full word.
  - Unselected lanes are preserved.
- Legality rules:
  - H/HU requires ALUResult[0] = 0.
  - W requires ALUResult[1:0] = 00.
  - Stores with funct3 = 100 or 101 are illegal.
  - funct3 = 011, 110, 111 is illegal for both loads and stores.
- Illegal store: array unchanged, StoreCount unchanged, AccessFault = 1.
- Illegal load (MemRead = 1): RD = 0, AccessFault = 1.
- AccessFault is 0 whenever MemRead = 0 and MemWrite = 0.
- At a clk edge with AccessFault = 1:
  - FaultSticky <= 1.
  - If FaultSticky was 0, FaultAddr <= ALUResult. Later faults do not overwrite FaultAddr.
- StoreCount increments by 1 at each edge with a legal store; it wraps from 0xFFFF to 0x0000.
- Read and write to the same word in the same cycle: RD shows the pre-write contents; new data is visible after the edge.
- MemRead = 1 and MemWrite = 1 together: both are performed; legality is evaluated once from funct3 and the address.

Optional Feature:
- Macro: LSU_MMIO_EN.
- Defined: adds output port MmioOut[31:0], a register reset to 0.
  - An SW to address 0xFFFF_FF00 writes MmioOut instead of the array and increments StoreCount.
  - An LW from that address returns MmioOut.
  - Byte or halfword access to 0xFFFF_FF00–0xFFFF_FF03 is illegal and raises a fault.
- Not defined: no MmioOut port; 0xFFFF_FF00 is an ordinary wrapped array address (word index 0 at the defaults).

Test Plan:
- Reset then read: assert reset, release, MemRead = 1, LW at 0x0 -> RD = 0x00000000, FaultSticky = 0, StoreCount = 0.
- Byte store and sign extension: SW 0x11223344 @0x8, SB 0x000000F0 @0xA. Then LW @0x8 -> 0x11F03344; LB @0xA -> 0xFFFFFFF0; LBU @0xA -> 0x000000F0; StoreCount = 2.
- Halfword: SH 0x00008001 @0x12, then LH @0x12 -> 0xFFFF8001; LHU @0x12 -> 0x00008001; LW @0x10 -> 0x80010000.
- Misalignment: SW 0xDEADBEEF @0x6 -> AccessFault = 1 that cycle; array unchanged; after the edge FaultSticky = 1, FaultAddr = 0x6. A later LH @0x3 faults but leaves FaultAddr = 0x6.
- Wrap and same-cycle read/write: SW 0xAAAA5555 @0x100 (DEPTH 64), then LW @0x0 -> 0xAAAA5555. In a cycle where SW 0x1 @0x0 is issued with MemRead = 1, RD = 0xAAAA5555; the following cycle RD = 0x00000001.
- Reset mid-operation: with MemWrite = 1 and a legal SW, assert reset between edges -> the array clears immediately, FaultSticky = 0, StoreCount = 0, and no write occurs.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Load/store data memory for the single-cycle core: combinational loads, synchronous byte/half/word stores.
// Optional memory-mapped output register at 0xFFFF_FF00 when LSU_MMIO_EN is defined.
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] RD,
  output logic        AccessFault,
  output logic        FaultSticky,
  output logic [31:0] FaultAddr,
  output logic [15:0] StoreCount
`ifdef LSU_MMIO_EN
  ,
  output logic [31:0] MmioOut
`endif
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      word;
  logic [31:0]      rword;
  logic             is_mmio;
  logic             size_ok;
  logic             load_legal;
  logic             store_legal;
  logic             store_ok;
  logic [3:0]       be;
  logic [31:0]      wmerge;
  logic [31:0]      wnew;
  logic [31:0]      ld;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = b;
    sx = 32'(sb);
    return sgn ? sx : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    sh = h;
    sx = 32'(sh);
    return sgn ? sx : {16'd0, h};
  endfunction

  assign idx  = ALUResult[IDX_W+1:2];
  assign word = mem[idx];

`ifdef LSU_MMIO_EN
  assign is_mmio = (ALUResult[31:2] == 30'h3FFF_FFC0);
  assign rword   = is_mmio ? MmioOut : word;
`else
  logic unused_upper;
  assign unused_upper = ^ALUResult[31:IDX_W+2];
  assign is_mmio      = 1'b0;
  assign rword        = word;
`endif

  always_comb begin
    case (funct3)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: size_ok = ~ALUResult[0];
      3'b010:         size_ok = (ALUResult[1:0] == 2'b00);
      default:        size_ok = 1'b0;
    endcase
  end

  // The MMIO register only accepts full-word accesses; unsigned variants are load-only.
  assign load_legal  = size_ok && !(is_mmio && funct3 != 3'b010);
  assign store_legal = load_legal && !funct3[2];
  assign store_ok    = MemWrite && store_legal;
  assign AccessFault = (MemRead && !load_legal) || (MemWrite && !store_legal);

  always_comb begin
    be     = 4'b1111;
    wmerge = WriteData;
    case (funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << ALUResult[1:0];
        wmerge = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be     = ALUResult[1] ? 4'b1100 : 4'b0011;
        wmerge = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      wnew[8*i +: 8] = be[i] ? wmerge[8*i +: 8] : word[8*i +: 8];
    end
  end

  always_comb begin
    ld = 32'd0;
    case (funct3)
      3'b000:  ld = ext8(rword[{ALUResult[1:0], 3'b000} +: 8], 1'b1);
      3'b100:  ld = ext8(rword[{ALUResult[1:0], 3'b000} +: 8], 1'b0);
      3'b001:  ld = ext16(rword[{ALUResult[1], 4'b0000} +: 16], 1'b1);
      3'b101:  ld = ext16(rword[{ALUResult[1], 4'b0000} +: 16], 1'b0);
      3'b010:  ld = rword;
      default: ld = 32'd0;
    endcase
  end

  assign RD = (MemRead && load_legal) ? ld : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
      FaultSticky <= 1'b0;
      FaultAddr   <= 32'd0;
      StoreCount  <= 16'd0;
`ifdef LSU_MMIO_EN
      MmioOut     <= 32'd0;
`endif
    end else begin
      if (store_ok && !is_mmio) begin
        mem[idx] <= wnew;
      end
`ifdef LSU_MMIO_EN
      if (store_ok && is_mmio) begin
        MmioOut <= WriteData;
      end
`endif
      if (store_ok) begin
        StoreCount <= StoreCount + 16'd1;
      end
      // Only the first fault since reset latches its address.
      if (AccessFault) begin
        FaultSticky <= 1'b1;
        if (!FaultSticky) begin
          FaultAddr <= ALUResult;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: stimulus queues expectations per cycle, a negedge monitor checks them.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [2:0]  funct3;
  logic [31:0] RD;
  logic        AccessFault;
  logic        FaultSticky;
  logic [31:0] FaultAddr;
  logic [15:0] StoreCount;
`ifdef LSU_MMIO_EN
  logic [31:0] MmioOut;
`endif

  data_memory_lsu #(.DEPTH_WORDS(64), .IDX_W(6)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUResult(ALUResult), .WriteData(WriteData), .funct3(funct3),
    .RD(RD), .AccessFault(AccessFault), .FaultSticky(FaultSticky),
    .FaultAddr(FaultAddr), .StoreCount(StoreCount)
`ifdef LSU_MMIO_EN
    , .MmioOut(MmioOut)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_RD = 0, K_AF = 1, K_FS = 2, K_FA = 3, K_SC = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RD:    return RD;
      K_AF:    return {31'd0, AccessFault};
      K_FS:    return {31'd0, FaultSticky};
      K_FA:    return FaultAddr;
      default: return {16'd0, StoreCount};
    endcase
  endfunction

  // Monitor: check every expectation that belongs to the current cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sbq.pop_front();
      a = actual(e.kind);
      n_cmp++;
      if (e.cyc != cyc || a !== e.exp) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", e.name, e.cyc, a, e.exp);
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    @(posedge clk);
    #1;
    MemWrite  = we;
    MemRead   = re;
    ALUResult = addr;
    WriteData = wd;
    funct3    = f3;
  endtask

  task automatic expect_v(input int kind, input string name, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sbq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    ALUResult = 32'd0; WriteData = 32'd0; funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    drive(0, 1, 32'h0, 0, 3'b010);
    expect_v(K_RD, "reset_rd", 32'h0);
    expect_v(K_AF, "reset_af", 32'h0);
    expect_v(K_FS, "reset_fs", 32'h0);
    expect_v(K_SC, "reset_sc", 32'h0);

    drive(1, 0, 32'h8, 32'h11223344, 3'b010);
    expect_v(K_AF, "sw8_af", 32'h0);
    drive(1, 0, 32'hA, 32'h000000F0, 3'b000);
    drive(0, 1, 32'h8, 0, 3'b010);
    expect_v(K_RD, "lw8_merged", 32'h11F03344);
    expect_v(K_SC, "sc_after_2", 32'd2);
    drive(0, 1, 32'hA, 0, 3'b000);
    expect_v(K_RD, "lb_a", 32'hFFFFFFF0);
    drive(0, 1, 32'hA, 0, 3'b100);
    expect_v(K_RD, "lbu_a", 32'h000000F0);
    drive(0, 1, 32'hB, 0, 3'b000);
    expect_v(K_RD, "lb_b_pos", 32'h00000011);

    drive(1, 0, 32'h12, 32'h00008001, 3'b001);
    drive(0, 1, 32'h12, 0, 3'b001);
    expect_v(K_RD, "lh_12", 32'hFFFF8001);
    drive(0, 1, 32'h12, 0, 3'b101);
    expect_v(K_RD, "lhu_12", 32'h00008001);
    drive(0, 1, 32'h10, 0, 3'b010);
    expect_v(K_RD, "lw_10", 32'h80010000);
    expect_v(K_SC, "sc_after_3", 32'd3);

    drive(1, 0, 32'h6, 32'hDEADBEEF, 3'b010);
    expect_v(K_AF, "sw6_af", 32'h1);
    expect_v(K_FS, "fs_before_edge", 32'h0);
    drive(0, 1, 32'h4, 0, 3'b010);
    expect_v(K_RD, "lw4_unchanged", 32'h0);
    expect_v(K_AF, "lw4_af", 32'h0);
    expect_v(K_FS, "fs_set", 32'h1);
    expect_v(K_FA, "fa_first", 32'h6);
    expect_v(K_SC, "sc_no_inc_misaligned", 32'd3);
    drive(0, 1, 32'h3, 0, 3'b001);
    expect_v(K_AF, "lh3_af", 32'h1);
    expect_v(K_RD, "lh3_rd", 32'h0);
    drive(0, 0, 32'h8, 0, 3'b011);
    expect_v(K_AF, "idle_af", 32'h0);
    expect_v(K_RD, "idle_rd", 32'h0);
    expect_v(K_FA, "fa_kept", 32'h6);

    drive(1, 0, 32'h100, 32'hAAAA5555, 3'b010);
    drive(0, 1, 32'h0, 0, 3'b010);
    expect_v(K_RD, "wrap_lw0", 32'hAAAA5555);
    expect_v(K_SC, "sc_after_4", 32'd4);
    drive(1, 1, 32'h0, 32'h1, 3'b010);
    expect_v(K_RD, "rw_same_old", 32'hAAAA5555);
    drive(0, 1, 32'h0, 0, 3'b010);
    expect_v(K_RD, "rw_same_new", 32'h00000001);
    expect_v(K_SC, "sc_after_5", 32'd5);

    drive(0, 1, 32'h8, 0, 3'b011);
    expect_v(K_AF, "f3_011_af", 32'h1);
    expect_v(K_RD, "f3_011_rd", 32'h0);
    drive(1, 0, 32'h8, 32'h55, 3'b100);
    expect_v(K_AF, "sbu_store_af", 32'h1);
    drive(0, 1, 32'h8, 0, 3'b010);
    expect_v(K_RD, "sbu_no_write", 32'h11F03344);
    expect_v(K_SC, "sc_illegal_store", 32'd5);

    // Reset asserted between edges while a legal store with read is presented.
    drive(1, 1, 32'h8, 32'h12345678, 3'b010);
    #2 reset = 1'b1;
    expect_v(K_RD, "midrst_rd", 32'h0);
    expect_v(K_FS, "midrst_fs", 32'h0);
    expect_v(K_FA, "midrst_fa", 32'h0);
    expect_v(K_SC, "midrst_sc", 32'h0);
    drive(0, 1, 32'h8, 0, 3'b010);
    reset = 1'b0;
    expect_v(K_RD, "midrst_nowrite", 32'h0);
    expect_v(K_SC, "midrst_sc_after", 32'h0);
    drive(0, 1, 32'h10, 0, 3'b010);
    expect_v(K_RD, "midrst_w4_clear", 32'h0);

    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
